decode_stage: RTL and testbench

//   Registered RV32I decode pipeline stage between fetch and execute. Accepts
//   {instr, pc} over a valid/ready handshake. Decodes the full RV32I integer

---
 rtl/decode_stage.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: registered one-entry control bundle between fetch and
// execute, with flush, illegal-encoding detection and a hand-off counter.
module decode_stage #(
  parameter int XLEN             = 32,
  parameter int CNT_W            = 32,
  parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       alu_control,
  output logic             alu_src,
  output logic             pc_alu_src,
  output logic [1:0]       result_src,
  output logic             mem_write,
  output logic [2:0]       mem_funct3,
  output logic             reg_write,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic            alu_src;
    logic            pc_alu_src;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [2:0]      mem_funct3;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } id_ex_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASB = 4'b1010;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [3:0] alu_f3(input logic [2:0] f,
                                        input logic alt);
    logic [3:0] a;
    a = ALU_ADD;
    unique case (f)
      3'b000:  a = alt ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = alt ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign b_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign j_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};
  assign u_imm = {in_instr[31:12], 12'b0};

  logic f7_zero, f7_alt;
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  id_ex_t d;

  always_comb begin
    d            = '0;
    d.pc         = in_pc;
    d.rd         = in_instr[11:7];
    d.rs1        = in_instr[19:15];
    d.rs2        = in_instr[24:20];
    d.mem_funct3 = f3;
    unique case (1'b1)
      op == 7'b0000011: begin
        d.imm        = sx(i_imm);
        d.alu_src    = 1'b1;
        d.result_src = 2'b01;
        d.reg_write  = 1'b1;
        d.illegal    = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      op == 7'b0100011: begin
        d.imm       = sx(s_imm);
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.illegal   = (f3 > 3'b010);
      end
      op == 7'b0110011: begin
        d.alu       = alu_f3(f3, f7[5]);
        d.reg_write = 1'b1;
        d.illegal   = !(f7_zero || f7_alt) ||
                      (f7_alt && !(f3 == 3'b000 || f3 == 3'b101));
      end
      op == 7'b0010011: begin
        d.imm       = sx(i_imm);
        d.alu_src   = 1'b1;
        d.alu       = alu_f3(f3, (f3 == 3'b101) && f7[5]);
        d.reg_write = 1'b1;
        d.illegal   = ((f3 == 3'b001) && !f7_zero) ||
                      ((f3 == 3'b101) && !(f7_zero || f7_alt));
      end
      op == 7'b1100011: begin
        d.imm        = sx(b_imm);
        d.branch     = 1'b1;
        d.pc_alu_src = 1'b1;
        d.alu        = (f3[2:1] == 2'b10) ? ALU_SLT  :
                       (f3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
        d.illegal    = (f3[2:1] == 2'b01);
      end
      op == 7'b1101111: begin
        d.imm        = sx(j_imm);
        d.jump       = 1'b1;
        d.pc_alu_src = 1'b1;
        d.result_src = 2'b10;
        d.reg_write  = 1'b1;
      end
      op == 7'b1100111: begin
        d.imm        = sx(i_imm);
        d.jump       = 1'b1;
        d.alu_src    = 1'b1;
        d.result_src = 2'b10;
        d.reg_write  = 1'b1;
        d.illegal    = (f3 != 3'b000);
      end
      op == 7'b0110111: begin
        d.imm       = sx(u_imm);
        d.alu_src   = 1'b1;
        d.alu       = ALU_PASB;
        d.reg_write = 1'b1;
      end
      op == 7'b0010111: begin
        d.imm        = sx(u_imm);
        d.alu_src    = 1'b1;
        d.pc_alu_src = 1'b1;
        d.reg_write  = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // illegal bundles travel down the pipe but must not cause side effects
    if (d.illegal) begin
      d.reg_write = 1'b0;
      d.mem_write = 1'b0;
      d.branch    = 1'b0;
      d.jump      = 1'b0;
    end
    if (ZERO_RD_SUPPRESS && (d.rd == 5'd0)) d.reg_write = 1'b0;
  end

  id_ex_t     q;
  logic       valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic       load, kill;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;
  assign kill     = flush || (!load && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (valid_q && out_ready && !flush) cnt_q <= cnt_q + CNT_W'(1);
      if (kill) begin
        valid_q     <= 1'b0;
        q.reg_write <= 1'b0;
        q.mem_write <= 1'b0;
        q.branch    <= 1'b0;
        q.jump      <= 1'b0;
        q.illegal   <= 1'b0;
      end else if (load) begin
        q       <= d;
        valid_q <= 1'b1;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = q.pc;
  assign rd          = q.rd;
  assign rs1         = q.rs1;
  assign rs2         = q.rs2;
  assign imm         = q.imm;
  assign alu_control = q.alu;
  assign alu_src     = q.alu_src;
  assign pc_alu_src  = q.pc_alu_src;
  assign result_src  = q.result_src;
  assign mem_write   = q.mem_write;
  assign mem_funct3  = q.mem_funct3;
  assign reg_write   = q.reg_write;
  assign branch      = q.branch;
  assign jump        = q.jump;
  assign illegal     = q.illegal;
  assign dec_count   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage: hand-encoded RV32I words,
// backpressure, flush, illegal encodings and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm, dec_count;
  logic [4:0]  rd, rs1, rs2;
  logic [3:0]  alu_control;
  logic        alu_src, pc_alu_src, mem_write, reg_write;
  logic        branch, jump, illegal;
  logic [1:0]  result_src;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .alu_control(alu_control), .alu_src(alu_src),
    .pc_alu_src(pc_alu_src), .result_src(result_src),
    .mem_write(mem_write), .mem_funct3(mem_funct3),
    .reg_write(reg_write), .branch(branch), .jump(jump),
    .illegal(illegal), .dec_count(dec_count)
  );

  typedef struct packed {
    logic        part;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        as, pas;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  f3;
    logic        rw, br, jp, il;
  } b_t;

  b_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  function automatic b_t mk(logic [31:0] pc, logic [4:0] d, s1, s2,
                            logic [31:0] im, logic [3:0] alu,
                            logic as, pas, logic [1:0] rs, logic mw,
                            logic [2:0] f3, logic rw, br, jp);
    b_t e;
    e = '{part: 1'b0, v: 1'b1, pc: pc, rd: d, rs1: s1, rs2: s2,
          imm: im, alu: alu, as: as, pas: pas, rs: rs, mw: mw,
          f3: f3, rw: rw, br: br, jp: jp, il: 1'b0};
    return e;
  endfunction

  function automatic b_t mk_ill();
    b_t e;
    e = '0;
    e.part = 1'b1;
    e.v = 1'b1;
    e.il = 1'b1;
    return e;
  endfunction

  function automatic b_t obs();
    b_t o;
    o = '{part: 1'b0, v: out_valid, pc: out_pc, rd: rd, rs1: rs1,
          rs2: rs2, imm: imm, alu: alu_control, as: alu_src,
          pas: pc_alu_src, rs: result_src, mw: mem_write,
          f3: mem_funct3, rw: reg_write, br: branch, jp: jump,
          il: illegal};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_v(string tag, logic [63:0] o, logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk(string tag);
    b_t e, o;
    logic ok;
    o = obs();
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, o);
    end else begin
      e = sb[0];
      if (e.part)
        ok = ({o.v, o.rw, o.mw, o.br, o.jp, o.il} ===
              {e.v, e.rw, e.mw, e.br, e.jp, e.il});
      else
        ok = (o === e);
      assert (ok) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic send(logic [31:0] ins, logic [31:0] pc, b_t e,
                      string tag);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    chk(tag);
  endtask

  // with out_ready=1 the held entry leaves and a bubble follows
  task automatic drain(string tag);
    tick();
    void'(sb.pop_front());
    exp_cnt++;
    chk_v({tag, "_bubble"},
          {59'd0, out_valid, reg_write, mem_write, branch, jump}, 64'd0);
    chk_v({tag, "_cnt"}, 64'(dec_count), 64'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    #3;
    chk_v("reset_valid", 64'(out_valid), 64'd0);
    chk_v("reset_cnt", 64'(dec_count), 64'd0);
    chk_v("reset_bundle", {imm, 27'd0, rd, reg_write}, 64'd0);
    chk_v("reset_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;

    send(32'hFFB10093, 32'h100,
         mk(32'h100, 5'd1, 5'd2, 5'd27, 32'hFFFFFFFB, 4'b0000,
            1, 0, 2'b00, 0, 3'b000, 1, 0, 0), "addi");
    chk_v("addi_cnt0", 64'(dec_count), 64'd0);
    drain("addi");
    send(32'h402080B3, 32'h104,
         mk(32'h104, 5'd1, 5'd1, 5'd2, 32'h0, 4'b0001,
            0, 0, 2'b00, 0, 3'b000, 1, 0, 0), "sub");
    drain("sub");
    send(32'h40208033, 32'h108,
         mk(32'h108, 5'd0, 5'd1, 5'd2, 32'h0, 4'b0001,
            0, 0, 2'b00, 0, 3'b000, 0, 0, 0), "sub_x0");
    drain("sub_x0");
    send(32'h000080E7, 32'h10C,
         mk(32'h10C, 5'd1, 5'd1, 5'd0, 32'h0, 4'b0000,
            1, 0, 2'b10, 0, 3'b000, 1, 0, 1), "jalr");
    drain("jalr");
    send(32'h123450B7, 32'h110,
         mk(32'h110, 5'd1, 5'd8, 5'd3, 32'h12345000, 4'b1010,
            1, 0, 2'b00, 0, 3'b101, 1, 0, 0), "lui");
    drain("lui");
    send(32'h0020C463, 32'h114,
         mk(32'h114, 5'd8, 5'd1, 5'd2, 32'h8, 4'b0101,
            0, 1, 2'b00, 0, 3'b100, 0, 1, 0), "blt");
    drain("blt");
    send(32'h0020A223, 32'h118,
         mk(32'h118, 5'd4, 5'd1, 5'd2, 32'h4, 4'b0000,
            1, 0, 2'b00, 1, 3'b010, 0, 0, 0), "sw");
    drain("sw");
    send(32'h40525193, 32'h11C,
         mk(32'h11C, 5'd3, 5'd4, 5'd5, 32'h405, 4'b1001,
            1, 0, 2'b00, 0, 3'b101, 1, 0, 0), "srai");
    drain("srai");
    send(32'h0020B023, 32'h120, mk_ill(), "store_f3_011");
    drain("store_f3_011");

    // backpressure: second word waits until execute accepts the first
    out_ready = 1'b0;
    send(32'hFFB10093, 32'h200,
         mk(32'h200, 5'd1, 5'd2, 5'd27, 32'hFFFFFFFB, 4'b0000,
            1, 0, 2'b00, 0, 3'b000, 1, 0, 0), "bp_first");
    in_valid = 1'b1;
    in_instr = 32'h402080B3;
    in_pc    = 32'h204;
    sb.push_back(mk(32'h204, 5'd1, 5'd1, 5'd2, 32'h0, 4'b0001,
                    0, 0, 2'b00, 0, 3'b000, 1, 0, 0));
    chk_v("bp_in_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold");
      chk_v("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    chk_v("bp_hold_cnt", 64'(dec_count), 64'(exp_cnt));
    out_ready = 1'b1;
    #1;
    chk_v("bp_in_ready1", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    void'(sb.pop_front());
    exp_cnt++;
    chk("bp_second");
    chk_v("bp_cnt", 64'(dec_count), 64'(exp_cnt));
    drain("bp_second");

    // flush kills the held entry and drops the word offered alongside it
    send(32'h123450B7, 32'h300,
         mk(32'h300, 5'd1, 5'd8, 5'd3, 32'h12345000, 4'b1010,
            1, 0, 2'b00, 0, 3'b101, 1, 0, 0), "pre_flush");
    in_valid = 1'b1;
    in_instr = 32'h000080E7;
    in_pc    = 32'h304;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    void'(sb.pop_front());
    chk_v("flush_clear",
          {58'd0, out_valid, reg_write, mem_write, branch, jump, illegal},
          64'd0);
    chk_v("flush_cnt", 64'(dec_count), 64'(exp_cnt));
    tick();
    chk_v("flush_dropped", 64'(out_valid), 64'd0);
    chk_v("flush_cnt2", 64'(dec_count), 64'(exp_cnt));

    // illegal word held, then asynchronous reset mid-hold
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h400, mk_ill(), "illegal");
    tick();
    chk("illegal_hold");
    #2;
    rst_n = 1'b0;
    #1;
    chk_v("async_rst_valid", 64'(out_valid), 64'd0);
    chk_v("async_rst_cnt", 64'(dec_count), 64'd0);
    chk_v("async_rst_ill", {62'd0, illegal, in_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
